// File: rtl/countdown_bcd_core.sv
// Countdown timer core: HH:MM:SS:cc BCD counter with load validation and
// an IDLE/RUN/PAUSE/DONE controller. All outputs are registered.
// Optional build macro COUNTDOWN_DONE_BLINK_EN blinks the digit enables in DONE.
module countdown_bcd_core #(
    parameter int unsigned BLINK_TICKS = 50
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        CE,
    input  logic        LOAD,
    input  logic [23:0] LOAD_VAL,
    input  logic        START,
    input  logic        STOP,
    output logic [31:0] DIGITS,
    output logic [7:0]  DP,
    output logic [7:0]  E,
    output logic        RUNNING,
    output logic        DONE,
    output logic        LOAD_ERR
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    // Points after H units, M units and S units.
    localparam logic [7:0] DpPattern = 8'b0101_0100;

    // A zero half-period would make the blink counter compare meaningless.
    if (BLINK_TICKS == 0) begin : g_bad_blink_ticks
        $error("BLINK_TICKS must be non-zero");
    end

    state_e      state_q, state_d;
    logic [31:0] count_d;
    logic [31:0] count_dec;
    logic        load_ok;
    logic        load_err_d;
    logic [7:0]  e_d;

    // One-centisecond BCD decrement; digit i lives at [4i+3:4i], tens of S and M wrap to 5.
    function automatic logic [31:0] bcd_dec(input logic [31:0] v);
        logic [31:0] r;
        logic        borrow;
        logic [3:0]  dig;
        logic [3:0]  lim;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dig = v[4*i +: 4];
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (borrow) begin
                if (dig == 4'd0) begin
                    r[4*i +: 4] = lim;
                end else begin
                    r[4*i +: 4] = dig - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign count_dec = bcd_dec(DIGITS);

    // Load value must be BCD with minute and second tens no greater than 5.
    always_comb begin
        load_ok = (LOAD_VAL[15:12] <= 4'd5) && (LOAD_VAL[7:4] <= 4'd5);
        for (int i = 0; i < 6; i++) begin
            if (LOAD_VAL[4*i +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    // Next-state, count and load-error decode; LOAD outranks STOP outranks START.
    always_comb begin
        state_d    = state_q;
        count_d    = DIGITS;
        load_err_d = 1'b0;
        case (state_q)
            StRun: begin
                if (CE) begin
                    count_d = count_dec;
                end
                // Reaching zero wins over a simultaneous STOP so a paused zero never exists.
                if (CE && count_dec == 32'd0) begin
                    state_d = StDone;
                end else if (STOP) begin
                    state_d = StPause;
                end
            end
            StIdle, StPause, StDone: begin
                if (LOAD) begin
                    if (load_ok) begin
                        count_d = {LOAD_VAL, 8'h00};
                        state_d = StIdle;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end else if (START && state_q != StDone && DIGITS != 32'd0) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef COUNTDOWN_DONE_BLINK_EN
    logic [15:0] blink_cnt_q, blink_cnt_d;
    logic        blank_q, blank_d;

    // Half-period counter runs on CE only while staying in DONE; entry restarts lit.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blank_d     = blank_q;
        if (state_d != StDone) begin
            blink_cnt_d = '0;
            blank_d     = 1'b0;
        end else if (state_q == StDone && CE) begin
            if (blink_cnt_q == 16'(BLINK_TICKS - 1)) begin
                blink_cnt_d = '0;
                blank_d     = ~blank_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end
        e_d = blank_d ? 8'h00 : 8'hFF;
    end

    // Blink state registers.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
        end
    end
`else
    assign e_d = 8'hFF;
`endif

    // Controller state and registered outputs.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q  <= StIdle;
            DIGITS   <= '0;
            E        <= 8'hFF;
            DP       <= DpPattern;
            RUNNING  <= 1'b0;
            DONE     <= 1'b0;
            LOAD_ERR <= 1'b0;
        end else begin
            state_q  <= state_d;
            DIGITS   <= count_d;
            E        <= e_d;
            DP       <= DpPattern;
            RUNNING  <= (state_d == StRun);
            DONE     <= (state_d == StDone);
            LOAD_ERR <= load_err_d;
        end
    end

endmodule

// File: doc/countdown_bcd_core.md
COUNTDOWN_BCD_CORE -- requirements
Module: countdown_bcd_core

Interface
REQ-001 SHALL have parameter BLINK_TICKS, default 50, CE ticks per DONE-blink half-period.
REQ-002 SHALL have ports, clock and reset first:
- CLK  in  1  clock, all state changes on rising edge.
- CLR  in  1  reset, asynchronous, active-low.
- CE  in  1  100 Hz tick enable, one CLK wide.
- LOAD  in  1  load LOAD_VAL.
- LOAD_VAL  in  24  BCD HH:MM:SS, [23:20] H tens ... [3:0] S units.
- START  in  1  start/resume.
- STOP  in  1  pause.
- DIGITS  out  32  BCD HH:MM:SS:cc, [3:0] cc units ... [31:28] H tens, display-driver digit order.
- DP  out  8  decimal-point vector.
- E  out  8  digit enable vector.
- RUNNING  out  1  high in RUN.
- DONE  out  1  high in DONE.
- LOAD_ERR  out  1  one-cycle pulse on rejected LOAD.

Function
REQ-003 SHALL implement FSM IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-004 SHALL accept LOAD in IDLE, PAUSE, DONE: count <= LOAD_VAL with cc = 00; next state IDLE; ignored in RUN.
REQ-005 SHALL reject LOAD if any digit > 9 or M tens > 5 or S tens > 5: count and state unchanged, LOAD_ERR = 1 next cycle.
REQ-006 SHALL move IDLE/PAUSE -> RUN on START when count != 0; START with count == 0 ignored.
REQ-007 SHALL move RUN -> PAUSE on STOP; STOP outside RUN ignored.
REQ-008 SHALL give priority LOAD > STOP > START when asserted in the same cycle.
REQ-009 SHALL decrement count by 1 cc on each CE while the registered state is RUN, including the cycle STOP is sampled.
REQ-010 SHALL borrow BCD-correctly: cc 00 -> 99 with borrow, S 00 -> 59, M 00 -> 59, H 00 -> 99; max 99:59:59:99.
REQ-011 SHALL enter DONE on the CE edge at which count becomes 00:00:00:00; no wrap below zero.
REQ-012 SHALL leave DONE only via LOAD or reset; START/STOP ignored in DONE.
REQ-013 SHALL update DIGITS exactly one CLK after the sampled CE edge.
REQ-014 SHALL drive DP = 8'b01010100 (points after H, M, S units) constantly.
REQ-015 SHALL drive E = 8'hFF in IDLE, RUN, PAUSE.
REQ-016 SHALL hold RUNNING = (state == RUN) and DONE = (state == DONE).

Reset
REQ-017 SHALL on CLR low, asynchronously: state IDLE, DIGITS 0, E 8'hFF, DP 8'b01010100, RUNNING 0, DONE 0, LOAD_ERR 0, blink counter 0.
REQ-018 SHALL abort any run on reset mid-count; count not retained.

Configuration
REQ-019 SHALL honour macro COUNTDOWN_DONE_BLINK_EN.
- Defined: in DONE, E toggles between 8'hFF and 8'h00 every BLINK_TICKS CE ticks, starting 8'hFF on DONE entry.
- Undefined: E = 8'hFF in DONE; no blink counter built.

Verification
REQ-020 SHALL cover these directed scenarios:
- LOAD 0x000002, START, 200 CE -> DIGITS reaches 0, DONE = 1 after 200th CE, RUNNING = 0.
- LOAD 0x010000, START, 1 CE -> DIGITS = 0x00595999.
- LOAD 0x006A00 -> LOAD_ERR one pulse, DIGITS unchanged, state unchanged.
- RUN with STOP and CE in the same cycle -> one decrement, then PAUSE; further CE give no change; START resumes.
- CLR low mid-RUN -> immediate reset values; START with zero count stays IDLE.
- BLINK_EN defined, BLINK_TICKS = 50, reach DONE -> E = FF for 50 CE, 00 for 50 CE, repeating; LOAD exits to IDLE with E = FF.
